// File: rtl/audio_fifo_pkg.sv
// Shared sizing constants for the audio sample FIFO.
// Optional drop counter in the top level is enabled by defining AUDIO_FIFO_DROP_CNT_EN.
package audio_fifo_pkg;

    localparam int unsigned WIDTH_DEF = 16;
    localparam int unsigned DEPTH_DEF = 256;
    localparam int unsigned AW_DEF    = $clog2(DEPTH_DEF);
    localparam int unsigned UW_DEF    = AW_DEF + 1;

endpackage

// File: rtl/audio_sample_fifo_ram.sv
// Simple dual-port sample RAM: one write port, one registered read port with enable.
// No reset on the array or read register so it maps onto block RAM.
module audio_sample_fifo_ram
    import audio_fifo_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned AW    = AW_DEF
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [0:(1<<AW)-1];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read register holds its value when no pop is accepted.
    always_ff @(posedge clk) begin
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/audio_sample_fifo.sv
// Single-clock PCM sample FIFO (ADC write side, CPU PIO read side) with sticky error flags.
// Define AUDIO_FIFO_DROP_CNT_EN to add the saturating drop_cnt output.
module audio_sample_fifo
    import audio_fifo_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             sclr,
    input  logic             wrreq,
    input  logic [WIDTH-1:0] data,
    input  logic             rdreq,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    output logic             rdempty,
    output logic             wrfull,
    output logic [AW:0]      usedw,
    output logic             overflow,
    output logic             underflow
`ifdef AUDIO_FIFO_DROP_CNT_EN
    ,
    output logic [15:0]      drop_cnt
`endif
);

    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [AW:0]      used_d;
    logic             rdempty_q, rdempty_d;
    logic             wrfull_q, wrfull_d;
    logic             q_valid_q, q_valid_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             loaded_q, loaded_d;
    logic             wr_acc, rd_acc;
    logic [WIDTH-1:0] ram_rdata;

    assign wr_acc = wrreq & ~wrfull_q & ~sclr;
    assign rd_acc = rdreq & ~rdempty_q & ~sclr;

    always_comb begin
        wr_ptr_d    = wr_ptr_q + {{AW{1'b0}}, wr_acc};
        rd_ptr_d    = rd_ptr_q + {{AW{1'b0}}, rd_acc};
        overflow_d  = overflow_q | (wrreq & wrfull_q);
        underflow_d = underflow_q | (rdreq & rdempty_q);
        q_valid_d   = rd_acc;
        loaded_d    = loaded_q | rd_acc;
        if (sclr) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        // Flags derive from next-state pointers so they change on the same edge.
        used_d    = wr_ptr_d - rd_ptr_d;
        rdempty_d = (used_d == '0);
        wrfull_d  = (used_d == FULL_LVL);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            rdempty_q   <= 1'b1;
            wrfull_q    <= 1'b0;
            q_valid_q   <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            loaded_q    <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            rdempty_q   <= rdempty_d;
            wrfull_q    <= wrfull_d;
            q_valid_q   <= q_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            loaded_q    <= loaded_d;
        end
    end

    audio_sample_fifo_ram #(
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .we_i    (wr_acc),
        .waddr_i (wr_ptr_q[AW-1:0]),
        .wdata_i (data),
        .re_i    (rd_acc),
        .raddr_i (rd_ptr_q[AW-1:0]),
        .rdata_o (ram_rdata)
    );

    // RAM read register has no reset; mask it until the first pop after reset.
    assign q         = loaded_q ? ram_rdata : '0;
    assign q_valid   = q_valid_q;
    assign rdempty   = rdempty_q;
    assign wrfull    = wrfull_q;
    assign usedw     = wr_ptr_q - rd_ptr_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

`ifdef AUDIO_FIFO_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (sclr) begin
            drop_cnt_d = '0;
        end else if (wrreq && wrfull_q && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

endmodule
